core5_cpu_2_oci_dct_packer: RTL
===============================

CORE5_CPU_2_OCI_DCT_PACKER -- requirements
Module: core5_cpu_2_oci_dct_packer

Interface
REQ-001 Parameter: SLOTS, default 15, number of 2-bit trace slots per word; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ev_valid  input  1  one trace event offered this cycle; events are never stalled.
REQ-005 ev_code  input  2  trace code of the event.
REQ-006 flush  input  1  level request to emit a partial buffer.
REQ-007 test_end_req  input  1  pulse; starts the end-of-test sequence.
REQ-008 word_ready  input  1  downstream accepts word_data this cycle.
REQ-009 dct_buffer  output  2*SLOTS  live packing buffer; slot i occupies bits [2i+1:2i].
REQ-010 dct_count  output  4  filled slots, 0..SLOTS.
REQ-011 word_valid  output  1  output holding register holds a word.
REQ-012 word_data  output  2*SLOTS  emitted word.
REQ-013 word_count  output  4  valid slots in word_data.
REQ-014 overflow  output  1  sticky event-drop flag.
REQ-015 test_ending  output  1  high in states FLUSH and DRAIN.
REQ-016 test_has_ended  output  1  high in state ENDED.

Function
REQ-017 The output register shall be free when word_valid=0 or word_ready=1.
REQ-018 Transfer condition T shall be: output register free AND (dct_count==SLOTS OR (flush=1 AND dct_count>0) OR (state==FLUSH AND dct_count>0)).
REQ-019 On T: word_data<=dct_buffer, word_count<=dct_count, word_valid<=1.
REQ-020 On T with ev_valid=1 in RUN: dct_buffer<=ev_code in slot 0 with other bits 0, and dct_count<=1. On T with no accepted event: dct_buffer<=0, dct_count<=0.
REQ-021 Without T, ev_valid=1 in RUN and dct_count<SLOTS: write ev_code to slot dct_count and increment dct_count.
REQ-022 Without T, ev_valid=1 in RUN and dct_count==SLOTS: drop the event, leave the buffer unchanged, set overflow<=1.
REQ-023 Without T, word_valid=1 and word_ready=1: word_valid<=0.
REQ-024 Latency: the event that fills the last slot is visible in dct_count on the next edge. word_valid rises one edge later if the output register is free.
REQ-025 Flush with dct_count==0 shall emit no word.
REQ-026 Slots above dct_count in dct_buffer shall read 0.
REQ-027 FSM states: RUN, FLUSH, DRAIN, ENDED.
REQ-028 FSM transitions:
- RUN -> FLUSH on test_end_req.
- FLUSH -> DRAIN on T, or immediately when dct_count==0.
- DRAIN -> ENDED when word_valid==0, or when word_valid==1 with word_ready==1.
- ENDED is held until reset.
REQ-029 In FLUSH, DRAIN and ENDED, ev_valid shall be ignored without setting overflow. test_end_req outside RUN shall be ignored.
REQ-030 overflow shall clear only on reset.

Reset
REQ-031 On reset_n low, asynchronously and regardless of state:
- dct_buffer, dct_count, word_data, word_count, word_valid, overflow, test_ending, test_has_ended <= 0.
- state <= RUN.
REQ-032 Operation shall resume on the first clk edge after reset_n deasserts. A reset asserted mid-word shall discard all partial and held data.

Verification (SLOTS=15)
REQ-033 Reset: reset_n low for 3 cycles with events driven -> all outputs 0, state RUN.
REQ-034 15 events with codes i%4 and word_ready=1 -> exactly one word: word_data=0x24E4E4E4, word_count=0xF, then dct_count=0.
REQ-035 Flush: events 3,3,1, then flush for 1 cycle -> word_data=0x0000001F, word_count=3, dct_count=0; a second flush pulse emits nothing.
REQ-036 Backpressure: word_ready=0 and 31 events -> first word held, buffer full with 15 slots, event 31 dropped, overflow=1. Then word_ready=1 -> two words in order, overflow stays 1.
REQ-037 End: 5 events, word_ready=0, test_end_req pulse -> test_ending=1, word_count=5 held. Events ignored and overflow stays 0. Raise word_ready -> next edge test_ending=0 and test_has_ended=1, held until reset.
REQ-038 Simultaneous event on the transfer edge with the buffer full and the output free -> new code lands in slot 0 and dct_count=1; no drop.

Source files
------------

// File: rtl/core5_cpu_2_oci_dct_packer.sv
// core5_cpu_2_oci_dct_packer: packs 2-bit trace codes into SLOTS-wide words behind
// a single output holding register, with an end-of-test flush/drain sequence. Rev 1.0
`default_nettype none

module core5_cpu_2_oci_dct_packer #(
  parameter int SLOTS = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ev_valid,
  input  logic [1:0]         ev_code,
  input  logic               flush,
  input  logic               test_end_req,
  input  logic               word_ready,
  output logic [2*SLOTS-1:0] dct_buffer,
  output logic [3:0]         dct_count,
  output logic               word_valid,
  output logic [2*SLOTS-1:0] word_data,
  output logic [3:0]         word_count,
  output logic               overflow,
  output logic               test_ending,
  output logic               test_has_ended
);

  localparam logic [3:0] FULL_CNT = 4'(SLOTS);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ENDED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2*SLOTS-1:0] buf_q, buf_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2*SLOTS-1:0] wdata_q, wdata_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               wvalid_q, wvalid_d;
  logic               ovf_q, ovf_d;

  logic w_out_free;
  logic w_has_data;
  logic w_full;
  logic w_xfer;
  logic w_accept;

  assign w_out_free = !wvalid_q || word_ready;
  assign w_has_data = (cnt_q != 4'd0);
  assign w_full     = (cnt_q == FULL_CNT);
  assign w_xfer     = w_out_free &&
                      (w_full || (flush && w_has_data) ||
                       ((state_q == ST_FLUSH) && w_has_data));
  // Events only count while running; later they are silently discarded.
  assign w_accept   = ev_valid && (state_q == ST_RUN);

  always_comb begin
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    wcnt_d   = wcnt_q;
    wvalid_d = wvalid_q;
    ovf_d    = ovf_q;

    if (w_xfer) begin
      wdata_d  = buf_q;
      wcnt_d   = cnt_q;
      wvalid_d = 1'b1;
      buf_d    = '0;
      cnt_d    = 4'd0;
      if (w_accept) begin
        buf_d[1:0] = ev_code;
        cnt_d      = 4'd1;
      end
    end else begin
      if (w_accept) begin
        if (!w_full) begin
          for (int i = 0; i < SLOTS; i++) begin
            if (cnt_q == 4'(i)) buf_d[2*i +: 2] = ev_code;
          end
          cnt_d = cnt_q + 4'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (wvalid_q && word_ready) wvalid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (test_end_req) state_d = ST_FLUSH;
      ST_FLUSH: if (w_xfer || !w_has_data) state_d = ST_DRAIN;
      ST_DRAIN: if (!wvalid_q || word_ready) state_d = ST_ENDED;
      ST_ENDED: state_d = ST_ENDED;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      buf_q    <= '0;
      cnt_q    <= 4'd0;
      wdata_q  <= '0;
      wcnt_q   <= 4'd0;
      wvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      wcnt_q   <= wcnt_d;
      wvalid_q <= wvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign word_valid     = wvalid_q;
  assign word_data      = wdata_q;
  assign word_count     = wcnt_q;
  assign overflow       = ovf_q;
  assign test_ending    = (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
  assign test_has_ended = (state_q == ST_ENDED);

endmodule

`default_nettype wire
